// File: rtl/cache_fill_fsm_pkg.sv
// Shared types and geometry constants for the cache miss handler and the
// cache tag/index decode.
package cache_fill_fsm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // Byte offset within a 16-byte block, and word index within that block.
    localparam int unsigned BLOCK_OFFSET_BITS = 4;
    localparam int unsigned WORD_IDX_BITS     = 3;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter for one block fill: synchronous clear, count enable and a
// terminal-count flag marking the last word of the block.
module cache_fill_fsm_fill_counter
    import cache_fill_fsm_pkg::*;
#(
    parameter logic [WORD_IDX_BITS-1:0] LAST = '1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    output logic [WORD_IDX_BITS-1:0] count,
    output logic                     tc
);

    // Count register; clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WORD_IDX_BITS'(1);
        end
    end

    // Terminal count: the counter currently points at the last word.
    always_comb begin
        tc = (count == LAST);
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: on a sampled miss, fetches the 8-word block from main
// memory with back-to-back pipelined reads, writes each returned word into
// the data array and finally writes the tag. fsm_busy stalls the pipeline
// for the whole fill.
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned MEM_LATENCY     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    input  logic [DATA_W-1:0] memory_data,
    output logic              fsm_busy,
    output logic              mem_enable,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] fill_address,
    output logic [DATA_W-1:0] fill_data,
    output logic              write_tag_array
);

    localparam int unsigned BYTE_BITS = BLOCK_OFFSET_BITS - WORD_IDX_BITS;

    // The FSM is response-driven; latency is only sanity-checked here.
    if (WORDS_PER_BLOCK != (32'd1 << WORD_IDX_BITS) || MEM_LATENCY == 0) begin : g_param_check
        $error("cache_fill_fsm: WORDS_PER_BLOCK must be 2**WORD_IDX_BITS and MEM_LATENCY nonzero");
    end

    fill_state_t                           state;
    fill_state_t                           state_nx;
    // Only the block-number bits are stored; the offset bits are always zero.
    logic [ADDR_W-1:BLOCK_OFFSET_BITS]     block_base;
    logic                                  issue_done;
    logic                                  accept;
    logic [WORD_IDX_BITS-1:0]              issue_cnt;
    logic [WORD_IDX_BITS-1:0]              resp_cnt;
    logic                                  issue_tc;
    logic                                  resp_tc;
    logic                                  unused_offset;

    // A miss is only taken from IDLE; misses during a fill are ignored.
    always_comb begin
        accept        = (state == IDLE) && miss_detected;
        unused_offset = ^miss_address[BLOCK_OFFSET_BITS-1:0];
    end

    cache_fill_fsm_fill_counter #(
        .LAST (WORD_IDX_BITS'(WORDS_PER_BLOCK - 1))
    ) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (mem_enable),
        .count (issue_cnt),
        .tc    (issue_tc)
    );

    cache_fill_fsm_fill_counter #(
        .LAST (WORD_IDX_BITS'(WORDS_PER_BLOCK - 1))
    ) u_resp_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (write_data_array),
        .count (resp_cnt),
        .tc    (resp_tc)
    );

    // State register, latched block address and the all-requests-issued flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            block_base <= '0;
            issue_done <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                block_base <= miss_address[ADDR_W-1:BLOCK_OFFSET_BITS];
                issue_done <= 1'b0;
            end else if (mem_enable && issue_tc) begin
                issue_done <= 1'b1;
            end
        end
    end

    // Next state and strobes; word offsets are concatenated so the address never leaves the block.
    always_comb begin
        state_nx         = state;
        fsm_busy         = 1'b0;
        mem_enable       = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_address     = '0;
        fill_data        = memory_data;
        write_tag_array  = 1'b0;
        case (state)
            IDLE: begin
                if (miss_detected) begin
                    state_nx = FILL;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (!issue_done) begin
                    mem_enable     = 1'b1;
                    memory_address = {block_base, issue_cnt, {BYTE_BITS{1'b0}}};
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    fill_address     = {block_base, resp_cnt, {BYTE_BITS{1'b0}}};
                    if (resp_tc) begin
                        write_tag_array = 1'b1;
                        state_nx        = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with an in-order memory model.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0;
    logic        model_valid = 1'b0;
    logic [15:0] model_data = 16'h0;
    logic        spur_valid = 1'b0;
    logic [15:0] spur_data = 16'h0;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_enable;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] fill_address;
    logic [15:0] fill_data;
    logic        write_tag_array;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    bit          lat_mode = 1'b0;

    assign memory_data_valid = model_valid | spur_valid;
    assign memory_data       = spur_valid ? spur_data : model_data;

    cache_fill_fsm #(
        .WORDS_PER_BLOCK (8),
        .ADDR_W          (16),
        .DATA_W          (16),
        .MEM_LATENCY     (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_enable        (mem_enable),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_address      (fill_address),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: request seen in cycle c answers in cycle c+latency, in order.
    // Returned word for word index k is 0xA000 + k.
    typedef struct {
        int unsigned due;
        logic [15:0] data;
    } resp_t;

    resp_t       q[$];
    int unsigned last_due = 0;
    int unsigned m_lat;
    int unsigned m_due;
    int unsigned lat_tbl [8] = '{4, 6, 5, 6, 4, 5, 6, 4};

    always begin
        @(posedge clk);
        #1;
        if (rst_n && q.size() > 0 && q[0].due == cyc) begin
            model_valid = 1'b1;
            model_data  = q[0].data;
            void'(q.pop_front());
        end else begin
            model_valid = 1'b0;
        end
        @(negedge clk);
        if (!rst_n) begin
            q.delete();
            model_valid = 1'b0;
            last_due    = cyc;
        end else if (mem_enable) begin
            m_lat = lat_mode ? lat_tbl[memory_address[3:1]] : 4;
            m_due = cyc + m_lat;
            if (m_due <= last_due) m_due = last_due + 1;
            last_due = m_due;
            q.push_back('{m_due, 16'hA000 + {13'd0, memory_address[3:1]}});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs for a 4-cycle-latency fill, r = cycles since the accepting edge.
    task automatic chk_std(input string t, input logic [15:0] base, input int unsigned r);
        logic        eb, em, ew, et;
        logic [15:0] ema, efa, efd;
        eb  = (r >= 1 && r <= 12);
        em  = (r >= 1 && r <= 8);
        ew  = (r >= 5 && r <= 12);
        et  = (r == 12);
        ema = 16'(base + 2 * (r - 1));
        efa = 16'(base + 2 * (r - 5));
        efd = 16'(16'hA000 + (r - 5));
        chk($sformatf("%s c%0d busy", t, r), fsm_busy, eb);
        chk($sformatf("%s c%0d mem_enable", t, r), mem_enable, em);
        chk($sformatf("%s c%0d write_data", t, r), write_data_array, ew);
        chk($sformatf("%s c%0d write_tag", t, r), write_tag_array, et);
        if (em) chk($sformatf("%s c%0d mem_addr", t, r), memory_address, ema);
        if (ew) begin
            chk($sformatf("%s c%0d fill_addr", t, r), fill_address, efa);
            chk($sformatf("%s c%0d fill_data", t, r), fill_data, efd);
        end
    endtask

    task automatic chk_zero(input string t);
        chk({t, " busy"}, fsm_busy, 0);
        chk({t, " mem_enable"}, mem_enable, 0);
        chk({t, " mem_addr"}, memory_address, 0);
        chk({t, " write_data"}, write_data_array, 0);
        chk({t, " fill_addr"}, fill_address, 0);
        chk({t, " write_tag"}, write_tag_array, 0);
    endtask

    // Present a one-cycle miss; returns #1 into cycle 1 of the fill.
    task automatic issue_miss(input logic [15:0] a);
        @(posedge clk); #1;
        miss_detected = 1'b1;
        miss_address  = a;
        @(posedge clk); #1;
        miss_detected = 1'b0;
        miss_address  = 16'h0;
    endtask

    initial begin
        int unsigned k;
        int unsigned n_wr;
        int unsigned wc [8];
        logic        eb, ew;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // Basic fill of block 0x1230 with per-word data
        issue_miss(16'h1236);
        for (int unsigned r = 1; r <= 13; r++) begin
            @(negedge clk);
            chk_std("t1", 16'h1230, r);
        end

        // Miss held high, address changed mid-fill, back-to-back fills
        @(posedge clk); #1;
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        @(posedge clk); #1;
        for (int unsigned r = 1; r <= 26; r++) begin
            @(negedge clk);
            if (r == 4) miss_address = 16'h4000;
            if (r <= 13) chk_std("t3a", 16'h1230, r);
            else         chk_std("t3b", 16'h4000, r - 13);
            if (r == 14) begin
                miss_detected = 1'b0;
                miss_address  = 16'h0;
            end
        end

        // Spurious valid in IDLE
        @(posedge clk); #1;
        spur_valid = 1'b1;
        spur_data  = 16'hDEAD;
        @(negedge clk);
        chk("t4 idle write_data", write_data_array, 0);
        chk("t4 idle write_tag", write_tag_array, 0);
        chk("t4 idle busy", fsm_busy, 0);
        @(posedge clk); #1;
        spur_valid = 1'b0;
        @(negedge clk);
        chk("t4 after busy", fsm_busy, 0);
        chk("t4 after mem_enable", mem_enable, 0);

        // Top-of-address-space block
        issue_miss(16'hFFFE);
        for (int unsigned r = 1; r <= 13; r++) begin
            @(negedge clk);
            chk_std("t4", 16'hFFF0, r);
        end

        // Asynchronous reset in cycle 7 of a fill
        issue_miss(16'h2468);
        for (int unsigned r = 1; r <= 6; r++) begin
            @(negedge clk);
            chk_std("t5a", 16'h2460, r);
        end
        @(posedge clk); #2;
        chk("t5 pre busy", fsm_busy, 1);
        chk("t5 pre write_data", write_data_array, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("t5 async");
        @(negedge clk); #1;
        rst_n = 1'b1;
        for (int unsigned r = 1; r <= 6; r++) begin
            @(negedge clk);
            chk($sformatf("t5 post c%0d write_tag", r), write_tag_array, 0);
            chk($sformatf("t5 post c%0d write_data", r), write_data_array, 0);
            chk($sformatf("t5 post c%0d busy", r), fsm_busy, 0);
        end
        issue_miss(16'h3000);
        for (int unsigned r = 1; r <= 13; r++) begin
            @(negedge clk);
            chk_std("t5b", 16'h3000, r);
        end

        // Variable latency 4..6: writes land in cycles 5,8,9,10,11,12,13,14
        lat_mode = 1'b1;
        wc = '{5, 8, 9, 10, 11, 12, 13, 14};
        k = 0;
        n_wr = 0;
        issue_miss(16'h5552);
        for (int unsigned r = 1; r <= 15; r++) begin
            @(negedge clk);
            eb = (r <= 14);
            ew = (k < 8) && (r == wc[k]);
            chk($sformatf("t6 c%0d busy", r), fsm_busy, eb);
            chk($sformatf("t6 c%0d mem_enable", r), mem_enable, (r <= 8));
            chk($sformatf("t6 c%0d write_data", r), write_data_array, ew);
            chk($sformatf("t6 c%0d write_tag", r), write_tag_array, (r == 14));
            if (ew) begin
                chk($sformatf("t6 c%0d fill_addr", r), fill_address, 16'(16'h5550 + 2 * k));
                chk($sformatf("t6 c%0d fill_data", r), fill_data, 16'(16'hA000 + k));
                k++;
            end
            if (write_data_array) n_wr++;
        end
        chk("t6 write count", n_wr, 8);
        lat_mode = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
